multicycle_sequencer: RTL and testbench

MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

---
 rtl/multicycle_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB). It issues the datapath strobes,
// counts retired instructions and faults into HALT if a memory never answers.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  begin/resume from IDLE or HALT
//   imem_ready, dm_ready   instruction / data memory handshakes
//   reg_write .. is_halt   decoded control bits of the current IR
//   is_jz .. is_jump       decoded branch class of the current IR
//   flag_z/l/g             flags register outputs
//   imem_req .. dm_re      combinational strobes (state + current inputs)
//   state                  current state encoding
//   fault                  sticky memory-timeout flag
//   retired                retired-instruction count (wraps)
module multicycle_sequencer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             imem_ready,
  input  logic             dm_ready,
  input  logic             reg_write,
  input  logic             is_mem_access,
  input  logic             flags_write,
  input  logic             dm_write_enable,
  input  logic             is_halt,
  input  logic             is_jz,
  input  logic             is_jnz,
  input  logic             is_jl,
  input  logic             is_jg,
  input  logic             is_jump,
  input  logic             flag_z,
  input  logic             flag_l,
  input  logic             flag_g,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_load,
  output logic             pc_src,
  output logic             rf_write,
  output logic             flags_load,
  output logic             dm_we,
  output logic             dm_re,
  output logic [2:0]       state,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               fault_q, fault_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire_c;
  logic               any_branch_c;
  logic               taken_c;
  logic               wait_hit_c;

  // Branch resolution from the decoded class and current flags.
  assign any_branch_c = is_jz | is_jnz | is_jl | is_jg | is_jump;
  assign taken_c      = is_jump | (is_jz & flag_z) | (is_jnz & ~flag_z) |
                        (is_jl & flag_l) | (is_jg & flag_g);

  // The current not-ready cycle is the MEM_TIMEOUT-th one in a row.
  assign wait_hit_c = (wait_q >= WAIT_W'(MEM_TIMEOUT - 1));

  // State register and bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      fault_q   <= fault_d;
      retired_q <= retired_d;
    end
  end

  // Next state and strobes; the wait counter is zero outside stalled FETCH/MEM.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    fault_d    = fault_q;
    retire_c   = 1'b0;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_load    = 1'b0;
    pc_src     = 1'b0;
    rf_write   = 1'b0;
    flags_load = 1'b0;
    dm_we      = 1'b0;
    dm_re      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (wait_hit_c) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        flags_load = flags_write;
        // Branches retire here; the branch class wins over a memory access.
        if (any_branch_c) begin
          pc_load  = 1'b1;
          pc_src   = taken_c;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (is_mem_access) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dm_we = dm_write_enable;
        dm_re = ~dm_write_enable;
        if (dm_ready) begin
          if (dm_write_enable) begin
            pc_load  = 1'b1;
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_hit_c) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        rf_write = reg_write;
        pc_load  = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          fault_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;

  assign state   = state_q;
  assign fault   = fault_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomised bench: builds an expected per-cycle trace from instruction-level
// rules (class, memory wait lengths, flags) and replays it against the DUT.
module tb_multicycle_sequencer;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned MEM_TIMEOUT = 15;

  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3,
                         MEM = 3'd4, WB = 3'd5, HALT = 3'd6;

  // Strobe bit positions in the comparison vector.
  localparam logic [7:0] B_IREQ = 8'h80, B_IRL = 8'h40, B_PCL = 8'h20, B_SRC = 8'h10,
                         B_RFW  = 8'h08, B_FLL = 8'h04, B_DWE = 8'h02, B_DRE = 8'h01;

  typedef struct packed {
    logic reg_write, is_mem, flags_write, dwe, is_halt;
    logic jz, jnz, jl, jg, jump;
    logic fz, fl, fg;
  } ctl_t;

  typedef struct {
    logic       start, imem_ready, dm_ready;
    ctl_t       ctl;
    logic [2:0] st;
    logic [7:0] strb;
    int         ret;
    logic       flt;
  } cyc_t;

  logic clk, rst_n, start, imem_ready, dm_ready;
  logic reg_write, is_mem_access, flags_write, dm_write_enable, is_halt;
  logic is_jz, is_jnz, is_jl, is_jg, is_jump, flag_z, flag_l, flag_g;
  logic imem_req, ir_load, pc_load, pc_src, rf_write, flags_load, dm_we, dm_re;
  logic [2:0]       state;
  logic             fault;
  logic [CNT_W-1:0] retired;

  cyc_t q[$];
  int   m_ret;
  logic m_fault;
  int   checks, errors;

  multicycle_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_ready(imem_ready), .dm_ready(dm_ready),
    .reg_write(reg_write), .is_mem_access(is_mem_access), .flags_write(flags_write),
    .dm_write_enable(dm_write_enable), .is_halt(is_halt),
    .is_jz(is_jz), .is_jnz(is_jnz), .is_jl(is_jl), .is_jg(is_jg), .is_jump(is_jump),
    .flag_z(flag_z), .flag_l(flag_l), .flag_g(flag_g),
    .imem_req(imem_req), .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src),
    .rf_write(rf_write), .flags_load(flags_load), .dm_we(dm_we), .dm_re(dm_re),
    .state(state), .fault(fault), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [7:0] strobes();
    return {imem_req, ir_load, pc_load, pc_src, rf_write, flags_load, dm_we, dm_re};
  endfunction

  task automatic push(input logic [2:0] st, input logic [7:0] strb, input logic s,
                      input logic ir, input logic dr, input ctl_t c);
    cyc_t e;
    e.start = s; e.imem_ready = ir; e.dm_ready = dr; e.ctl = c;
    e.st = st; e.strb = strb; e.ret = m_ret % (1 << CNT_W); e.flt = m_fault;
    q.push_back(e);
  endtask

  // Mostly short stalls, occasionally long enough to time out.
  function automatic int pick_wait();
    if ($urandom_range(0, 9) == 0) return int'($urandom_range(15, 20));
    return int'($urandom_range(0, 3));
  endfunction

  // Sit in HALT for a few cycles, then resume with start.
  task automatic gen_halt(input ctl_t c);
    int k;
    k = int'($urandom_range(0, 3));
    for (int i = 0; i < k; i++) push(HALT, 8'h00, 1'b0, rb(), rb(), c);
    push(HALT, 8'h00, 1'b1, rb(), rb(), c);
    m_fault = 1'b0;
  endtask

  // Expected trace of one instruction starting in FETCH.
  task automatic gen_instr();
    ctl_t       c;
    int         cls, w;
    logic       br, taken;
    logic [7:0] s;
    c   = ctl_t'(13'($urandom));
    cls = int'($urandom_range(0, 4));
    c.is_halt = 1'b0;
    if (cls != 1) {c.jz, c.jnz, c.jl, c.jg, c.jump} = 5'b0;
    case (cls)
      0: c.is_mem = 1'b0;
      1: if ({c.jz, c.jnz, c.jl, c.jg, c.jump} == 5'b0) c.jz = 1'b1;
      2: begin c.is_mem = 1'b1; c.dwe = 1'b0; end
      3: begin c.is_mem = 1'b1; c.dwe = 1'b1; end
      default: c.is_halt = 1'b1;
    endcase

    w = pick_wait();
    for (int i = 0; ; i++) begin
      if (i < w) begin
        push(FETCH, B_IREQ, rb(), 1'b0, rb(), c);
        if (i == int'(MEM_TIMEOUT) - 1) begin
          m_fault = 1'b1;
          gen_halt(c);
          return;
        end
      end else begin
        push(FETCH, B_IREQ | B_IRL, rb(), 1'b1, rb(), c);
        break;
      end
    end

    push(DECODE, 8'h00, rb(), rb(), rb(), c);
    if (c.is_halt) begin
      gen_halt(c);
      return;
    end

    br    = c.jz | c.jnz | c.jl | c.jg | c.jump;
    taken = c.jump | (c.jz & c.fz) | (c.jnz & ~c.fz) | (c.jl & c.fl) | (c.jg & c.fg);
    s     = c.flags_write ? B_FLL : 8'h00;
    if (br) begin
      push(EXEC, s | B_PCL | (taken ? B_SRC : 8'h00), rb(), rb(), rb(), c);
      m_ret++;
      return;
    end
    push(EXEC, s, rb(), rb(), rb(), c);

    if (c.is_mem) begin
      s = c.dwe ? B_DWE : B_DRE;
      w = pick_wait();
      for (int i = 0; ; i++) begin
        if (i < w) begin
          push(MEM, s, rb(), rb(), 1'b0, c);
          if (i == int'(MEM_TIMEOUT) - 1) begin
            m_fault = 1'b1;
            gen_halt(c);
            return;
          end
        end else if (c.dwe) begin
          push(MEM, s | B_PCL, rb(), rb(), 1'b1, c);
          m_ret++;
          return;
        end else begin
          push(MEM, s, rb(), rb(), 1'b1, c);
          break;
        end
      end
    end

    push(WB, B_PCL | (c.reg_write ? B_RFW : 8'h00), rb(), rb(), rb(), c);
    m_ret++;
  endtask

  task automatic apply(input cyc_t e);
    start = e.start; imem_ready = e.imem_ready; dm_ready = e.dm_ready;
    {reg_write, is_mem_access, flags_write, dm_write_enable, is_halt,
     is_jz, is_jnz, is_jl, is_jg, is_jump, flag_z, flag_l, flag_g} = e.ctl;
  endtask

  initial begin
    cyc_t z;
    ctl_t c0;
    checks = 0; errors = 0; m_ret = 0; m_fault = 1'b0;
    c0 = '0;
    z.start = 1'b0; z.imem_ready = 1'b0; z.dm_ready = 1'b0; z.ctl = c0;
    z.st = IDLE; z.strb = 8'h00; z.ret = 0; z.flt = 1'b0;
    rst_n = 1'b0;
    apply(z);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'(IDLE));
    chk("reset_strobes", 32'(strobes()), 32'h0);
    chk("reset_retired", 32'(retired), 32'h0);
    chk("reset_fault", 32'(fault), 32'h0);
    rst_n = 1'b1;

    push(IDLE, 8'h00, 1'b0, rb(), rb(), c0);
    push(IDLE, 8'h00, 1'b0, rb(), rb(), c0);
    push(IDLE, 8'h00, 1'b1, rb(), rb(), c0);
    for (int n = 0; n < 300; n++) gen_instr();

    for (int i = 0; i < q.size(); i++) begin
      apply(q[i]);
      @(negedge clk);
      chk($sformatf("state[%0d]", i), 32'(state), 32'(q[i].st));
      chk($sformatf("strobes[%0d]", i), 32'(strobes()), 32'(q[i].strb));
      chk($sformatf("retired[%0d]", i), 32'(retired), 32'(q[i].ret));
      chk($sformatf("fault[%0d]", i), 32'(fault), 32'(q[i].flt));
      @(posedge clk);
      #1;
    end

    // Trace always ends in FETCH: run a load into a stalled MEM, then reset mid-cycle.
    z.imem_ready = 1'b1; z.dm_ready = 1'b0;
    c0.is_mem = 1'b1; c0.dwe = 1'b0; z.ctl = c0;
    apply(z);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mem_state", 32'(state), 32'(MEM));
    chk("mem_dm_re", 32'(strobes()), 32'(B_DRE));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'(IDLE));
    chk("async_strobes", 32'(strobes()), 32'h0);
    chk("async_retired", 32'(retired), 32'h0);
    chk("async_fault", 32'(fault), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
